store_unit: RTL

- Data-memory write initiator for the RV32 core; the store-side counterpart of the load/writeback path that consumes ReadData.
- Takes a store request from the execute stage (address, rs2 data, funct3) and derives byte enables and lane-replicated write data.
- Runs a req/ready + response handshake with data memory and stalls the core until the write completes or faults.

---
 rtl/rv_mem_pkg.sv | 19 +
 rtl/store_align.sv | 37 +++
 rtl/store_unit.sv | 118 +++++++++++
 3 files changed

// File: rtl/rv_mem_pkg.sv
// Shared data-memory definitions: store widths, store FSM state encoding and fault causes.
package rv_mem_pkg;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef logic [1:0] store_state_t;
  localparam store_state_t ST_IDLE      = 2'd0;
  localparam store_state_t ST_REQ       = 2'd1;
  localparam store_state_t ST_WAIT_RESP = 2'd2;
  localparam store_state_t ST_DONE      = 2'd3;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_ACCESS   = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

endpackage

// File: rtl/store_align.sv
// Combinational store lane steering: byte enables, replicated write data and
// a misaligned/illegal flag from funct3 and the low address bits.
module store_align
  import rv_mem_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_data,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_misaligned
);

  always_comb begin
    o_be         = '0;
    o_wdata      = '0;
    o_misaligned = 1'b0;
    case (i_funct3)
      F3_SB: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_data[7:0]}};
      end
      F3_SH: begin
        o_be         = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata      = {2{i_data[15:0]}};
        o_misaligned = i_addr_lo[0];
      end
      F3_SW: begin
        o_be         = '1;
        o_wdata      = i_data;
        o_misaligned = (i_addr_lo != 2'b00);
      end
      default: o_misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_unit.sv
// Data-memory store initiator: steers store data into byte lanes, runs the
// req/ready + response handshake and stalls the core until retire or fault.
module store_unit
  import rv_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] ALU_result,
  input  logic [31:0] WriteData,
  output logic        StoreStall,
  output logic        StoreDone,
  output logic        StoreFault,
  output logic [1:0]  StoreFaultCause,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic        mem_rerr
);

  // A zero TIMEOUT_CYCLES would give a zero-width counter; keep one bit.
  localparam int unsigned TO_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  store_state_t r_state;
  logic [TO_W-1:0] r_cnt;
  logic [1:0]      r_cause;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic [3:0]      r_be;

  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_misaligned;
  logic        w_expire;

  store_align u_align (
    .i_funct3     (funct3),
    .i_addr_lo    (ALU_result[1:0]),
    .i_data       (WriteData),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_misaligned (w_misaligned)
  );

  assign w_expire = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_W'(TO_LAST));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_cause <= CAUSE_NONE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (MemWrite) begin
            if (w_misaligned) begin
              r_state <= ST_DONE;
              r_cause <= CAUSE_MISALIGN;
            end else begin
              r_state <= ST_REQ;
              r_cause <= CAUSE_NONE;
              r_cnt   <= '0;
              r_addr  <= {ALU_result[31:2], 2'b00};
              r_wdata <= w_wdata;
              r_be    <= w_be;
            end
          end
        end
        ST_REQ: begin
          if (TIMEOUT_CYCLES != 0) r_cnt <= r_cnt + TO_W'(1);
          // A response accepted together with ready takes priority over expiry.
          if (mem_ready && mem_rvalid) begin
            r_state <= ST_DONE;
            r_cause <= mem_rerr ? CAUSE_ACCESS : CAUSE_NONE;
          end else if (w_expire) begin
            r_state <= ST_DONE;
            r_cause <= CAUSE_TIMEOUT;
          end else if (mem_ready) begin
            r_state <= ST_WAIT_RESP;
          end
        end
        ST_WAIT_RESP: begin
          if (TIMEOUT_CYCLES != 0) r_cnt <= r_cnt + TO_W'(1);
          if (mem_rvalid) begin
            r_state <= ST_DONE;
            r_cause <= mem_rerr ? CAUSE_ACCESS : CAUSE_NONE;
          end else if (w_expire) begin
            r_state <= ST_DONE;
            r_cause <= CAUSE_TIMEOUT;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign StoreStall      = (r_state == ST_REQ) || (r_state == ST_WAIT_RESP) ||
                           ((r_state == ST_IDLE) && MemWrite);
  assign StoreDone       = (r_state == ST_DONE);
  assign StoreFault      = (r_state == ST_DONE) && (r_cause != CAUSE_NONE);
  assign StoreFaultCause = (r_state == ST_DONE) ? r_cause : CAUSE_NONE;
  assign mem_req         = (r_state == ST_REQ);
  assign mem_addr        = r_addr;
  assign mem_wdata       = r_wdata;
  assign mem_be          = r_be;

endmodule
